// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, LSB-first, one bit per clock through a single
// full-subtractor cell, with a Start/Busy/Done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] areg_q, breg_q, res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q, b_msb_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q, ovf_q;

    logic a_bit, b_bit, d_bit, br_next;
    logic accept, last_bit;

    // Full-subtractor cell
    assign a_bit   = areg_q[0];
    assign b_bit   = breg_q[0];
    assign d_bit   = a_bit ^ b_bit ^ br_q;
    assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    assign accept   = Start && ((state_q == IDLE) || (state_q == DONE));
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = Start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            areg_q  <= '0;
            breg_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                areg_q  <= A;
                breg_q  <= B;
                br_q    <= Bin;
                cnt_q   <= '0;
                a_msb_q <= A[WIDTH-1];
                b_msb_q <= B[WIDTH-1];
            end else if (state_q == SHIFT) begin
                areg_q <= areg_q >> 1;
                breg_q <= breg_q >> 1;
                res_q  <= {d_bit, res_q[WIDTH-1:1]};
                br_q   <= br_next;
                cnt_q  <= cnt_q + 1'b1;
                // Visible results only change on the edge entering DONE
                if (last_bit) begin
                    diff_q <= {d_bit, res_q[WIDTH-1:1]};
                    bout_q <= br_next;
                    ovf_q  <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
                end
            end
        end
    end

    assign Busy = (state_q == SHIFT);
    assign Done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table plus handshake corner-case sequences,
// with a scoreboard queue popped whenever Done is seen.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         bout, ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } res_t;

    res_t exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .Start (start),
        .A     (a),
        .B     (b),
        .Bin   (bin),
        .Busy  (busy),
        .Done  (done),
        .Diff  (diff),
        .Bout  (bout),
        .Ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mbin);
        logic [W:0] t;
        res_t       r;
        t      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        r.diff = t[W-1:0];
        r.bout = t[W];
        r.ovf  = (ma[W-1] != mb[W-1]) && (t[W-1] != ma[W-1]);
        return r;
    endfunction

    // Scoreboard: every Done pops one expected result
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got Done=1 expected no Done (diff=%0h)", diff);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("diff", diff, r.diff);
                    check("bout", bout, r.bout);
                    check("ovf", ovf, r.ovf);
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          input res_t e);
        int lat;
        int nb;
        @(negedge clk);
        a     = ta;
        b     = tb_;
        bin   = tbin;
        start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        nb    = busy ? 1 : 0;
        while (!done && lat < int'(W) + 6) begin
            @(negedge clk);
            lat++;
            if (busy) nb++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no Done after %0d cycles expected %0d", lat, W + 1);
        end else begin
            check("done_latency", lat, W + 1);
        end
        check("busy_cycles", nb, W);
    endtask

    vec_t vecs[8];

    initial begin
        int ndone;
        int last_done;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
        vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            res_t e;
            e.diff = vecs[i].diff;
            e.bout = vecs[i].bout;
            e.ovf  = vecs[i].ovf;
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, e);
        end

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra, rb;
            logic         rbin;
            ra   = W'($urandom_range(0, 255));
            rb   = W'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            run_op(ra, rb, rbin, model(ra, rb, rbin));
        end

        // Start during SHIFT is ignored; operand changes after acceptance have no effect
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h01;
        bin   = 1'b0;
        start = 1'b1;
        exp_q.push_back(model(8'h10, 8'h01, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ignored_start_done_count", ndone, 1);
        check("ignored_start_idle", busy, 0);

        // Leave nonzero Diff/Bout/Ovf so the reset clear is observable
        run_op(8'h00, 8'h80, 1'b0, model(8'h00, 8'h80, 1'b0));

        // Reset mid-operation
        @(negedge clk);
        a     = 8'h55;
        b     = 8'h11;
        start = 1'b1;
        exp_q.push_back(model(8'h55, 8'h11, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_diff", diff, 0);
        check("midrst_bout", bout, 0);
        check("midrst_ovf", ovf, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        run_op(8'h09, 8'h04, 1'b0, model(8'h09, 8'h04, 1'b0));

        // Back-to-back with Start held high
        @(negedge clk);
        a     = 8'h20;
        b     = 8'h10;
        bin   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h20, 8'h10, 1'b0));
        ndone     = 0;
        last_done = 0;
        for (int cyc = 1; cyc <= 60 && ndone < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone > 1) check("b2b_period", cyc - last_done, W + 1);
                else check("b2b_first_latency", cyc, W + 1);
                last_done = cyc;
                if (ndone == 3) start = 1'b0;
            end else if (ndone >= 1) begin
                check("b2b_diff_stable", diff, 8'h10);
            end
        end
        start = 1'b0;
        check("b2b_done_count", ndone, 3);

        repeat (12) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes Diff = A - B - Bin, LSB-first, one bit per clock.
- Built around a single full-subtractor cell, which is the borrow-propagating counterpart of the team's full adder.
- Uses a Start/Busy/Done handshake so a controller or sequencer can issue operations and collect results.
- Sits beside the combinational adder blocks as the area-cheap path for subtraction and magnitude comparison.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
Clk    input   1      rising-edge clock; the only clock in the block
Rst_n  input   1      asynchronous, active-low reset; deassertion is synchronous to Clk upstream
Start  input   1      request; sampled on a Clk edge when the FSM is in IDLE or DONE
A      input   WIDTH  minuend; captured on an accepted Start
B      input   WIDTH  subtrahend; captured on an accepted Start
Bin    input   1      borrow-in; captured on an accepted Start
Busy   output  1      high while bits are being processed
Done   output  1      one-cycle pulse; results are valid from this cycle onward
Diff   output  WIDTH  registered difference
Bout   output  1      borrow-out; 1 when A < B + Bin (unsigned)
Ovf    output  1      signed (two's-complement) overflow flag

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - FSM goes to IDLE.
  - Busy=0, Done=0, Diff=0, Bout=0, Ovf=0.
  - Internal shift registers, borrow flop and bit counter clear to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Start=1 on an edge: latch A, B and Bin into internal registers, clear the counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (Busy=1): each cycle, with a = areg[0], b = breg[0], br = borrow flop:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - d shifts into the result register from the MSB end; areg and breg shift right by 1.
  - The counter increments. After the WIDTH-th bit, go to DONE.
- DONE (1 cycle):
  - Done=1, Busy=0.
  - Diff, Bout and Ovf update on the edge entering DONE.
  - Ovf = (A[WIDTH-1] != B[WIDTH-1]) & (Diff[WIDTH-1] != A[WIDTH-1]), using the latched operands.
  - Next state: SHIFT if Start=1 (new operands latched, back-to-back operation), otherwise IDLE.
- Latency: Start accepted at edge N → Busy high for cycles N+1..N+WIDTH → Done high in cycle N+WIDTH+1.
- Throughput: one result per WIDTH+1 cycles.
- Start while in SHIFT: ignored, with no effect on the operation in flight.
- Changes on A, B or Bin after acceptance: no effect, because the operands are latched.
- Diff, Bout and Ovf hold their values until the next completion. Busy going high does not corrupt them.
- Reset asserted mid-operation: the operation is aborted immediately, all outputs return to reset values, and no Done is issued.
- Busy and Done are never high in the same cycle.
- Arithmetic is modulo 2^WIDTH. Bout is the final borrow flop value.

Test Plan:
- WIDTH=8: A=0x05, B=0x03, Bin=0 → Diff=0x02, Bout=0, Ovf=0; Done exactly 9 cycles after the Start edge; Busy high for 8 cycles.
- A=0x03, B=0x05, Bin=0 → Diff=0xFE, Bout=1, Ovf=0.
- A=0x80, B=0x01 → Diff=0x7F, Bout=0, Ovf=1. Then A=0x00, B=0x00, Bin=1 → Diff=0xFF, Bout=1, Ovf=0.
- Start pulsed with A=0x10, B=0x01; in cycle 3 of SHIFT, pulse Start again and change A to 0xFF → result Diff=0x0F; the second Start is ignored.
- Assert Rst_n=0 in cycle 4 of SHIFT → Busy, Done, Diff, Bout and Ovf drop to 0 asynchronously; no Done follows; the next Start with A=0x09, B=0x04 completes with Diff=0x05.
- Hold Start=1 continuously with A=0x20, B=0x10 → Done pulses every 9 cycles, each time with Diff=0x10; Diff stays stable between pulses.
